// File: rtl/adder_result_checker_if.sv
// Bus between the adder's stimulus/response side and the result checker.
// The checker drives the verdict, counter and sticky-failure signals.
interface adder_result_checker_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] dut_sum;
  logic             dut_cout;
  logic             clear;
  logic             chk_valid;
  logic             mismatch;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] err_count;
  logic             err_flag;
  logic [WIDTH:0]   err_exp;
  logic [WIDTH:0]   err_got;
  logic             halted;

  modport master (
    output in_valid, A, B, Cin, dut_sum, dut_cout, clear,
    input  chk_valid, mismatch, pass_count, err_count, err_flag, err_exp, err_got, halted
  );

  modport slave (
    input  in_valid, A, B, Cin, dut_sum, dut_cout, clear,
    output chk_valid, mismatch, pass_count, err_count, err_flag, err_exp, err_got, halted
  );
endinterface

// File: rtl/adder_result_checker.sv
// Self-checking monitor for a registered adder: computes the golden sum, delays it to match
// the adder latency and compares it with the adder output, keeping counts and first failure.
module adder_result_checker #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned CNT_W       = 16,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  adder_result_checker_if.slave bus
);
  localparam int unsigned SW = WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e           state_q, state_d;
  logic [LATENCY-1:0] pv_q, pv_d;
  logic [SW-1:0]    pe_q [LATENCY];
  logic [SW-1:0]    pe_d [LATENCY];
  logic             chk_valid_q, chk_valid_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             flag_q, flag_d;
  logic [SW-1:0]    exp_q, exp_d;
  logic [SW-1:0]    got_q, got_d;

  logic [SW-1:0] golden;
  logic [SW-1:0] got;
  logic          verdict_v;
  logic          verdict_bad;
  logic          count_en;

  always_comb begin
    golden      = {1'b0, bus.A} + {1'b0, bus.B} + SW'(bus.Cin);
    got         = {bus.dut_cout, bus.dut_sum};
    verdict_v   = pv_q[LATENCY-1];
    verdict_bad = verdict_v && (pe_q[LATENCY-1] != got);
    // clear beats a same-edge verdict; HALT freezes all bookkeeping
    count_en    = verdict_v && (state_q != StHalt) && !bus.clear;

    pv_d[0] = bus.in_valid;
    pe_d[0] = golden;
    for (int i = 1; i < int'(LATENCY); i++) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
    end

    chk_valid_d = verdict_v;
    mismatch_d  = verdict_bad;

    pass_d = pass_q;
    err_d  = err_q;
    flag_d = flag_q;
    exp_d  = exp_q;
    got_d  = got_q;
    if (bus.clear) begin
      pass_d = '0;
      err_d  = '0;
      flag_d = 1'b0;
      exp_d  = '0;
      got_d  = '0;
    end else if (count_en) begin
      if (!verdict_bad && pass_q != {CNT_W{1'b1}}) pass_d = pass_q + CNT_W'(1);
      if (verdict_bad && err_q != {CNT_W{1'b1}}) err_d = err_q + CNT_W'(1);
      if (verdict_bad && !flag_q) begin
        flag_d = 1'b1;
        exp_d  = pe_q[LATENCY-1];
        got_d  = got;
      end
    end

    state_d = state_q;
    if (bus.clear) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (verdict_v) state_d = (verdict_bad && STOP_ON_ERR) ? StHalt : StRun;
        StRun:  if (verdict_bad && STOP_ON_ERR) state_d = StHalt;
        StHalt: state_d = StHalt;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pv_q        <= '0;
      chk_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
      pass_q      <= '0;
      err_q       <= '0;
      flag_q      <= 1'b0;
      exp_q       <= '0;
      got_q       <= '0;
    end else begin
      state_q     <= state_d;
      pv_q        <= pv_d;
      chk_valid_q <= chk_valid_d;
      mismatch_q  <= mismatch_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      flag_q      <= flag_d;
      exp_q       <= exp_d;
      got_q       <= got_d;
    end
  end

  // Expected-value payload needs no reset: it is qualified by pv_q
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(LATENCY); i++) pe_q[i] <= pe_d[i];
  end

  assign bus.chk_valid  = chk_valid_q;
  assign bus.mismatch   = mismatch_q;
  assign bus.pass_count = pass_q;
  assign bus.err_count  = err_q;
  assign bus.err_flag   = flag_q;
  assign bus.err_exp    = exp_q;
  assign bus.err_got    = got_q;
  assign bus.halted     = (state_q == StHalt);
endmodule
